// File: rtl/producer_scheduler.sv
// producer_scheduler
//   Shares the wrapper FIFO write port between the Fibonacci and Timer
//   producers. One producer is granted at a time over a valid/ready
//   handshake; accepted words go into a 1-entry output stage that presents
//   data_1/data_1_en to the wrapper and holds the word while buffer_full=1.
//   Supports start/stop sequencing, fixed or round-robin selection and a
//   16-bit count of words written into the wrapper.
//
// Ports
//   clk_1        clock, all logic on posedge
//   rst          synchronous reset, active-high
//   start/stop   run control pulses
//   mode         00 Fibonacci only, 01 Timer only, 1x round-robin
//   fib_*        Fibonacci valid/data in, ready out (combinational)
//   tmr_*        Timer valid/data in, ready out (combinational)
//   buffer_full  wrapper full flag (inverse ready for data_1)
//   data_1_en    output stage holds a valid word (registered)
//   data_1       word presented to the wrapper (registered)
//   owner        current grant, 0 Fibonacci / 1 Timer (registered)
//   busy         1 in RUN or DRAIN (registered)
//   words_sent   words written since start, wraps FFFF->0000
module producer_scheduler #(
    parameter int DATA_W  = 16,
    parameter int QUANTUM = 4
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              fib_valid,
    input  logic [DATA_W-1:0] fib_data,
    output logic              fib_ready,
    input  logic              tmr_valid,
    input  logic [DATA_W-1:0] tmr_data,
    output logic              tmr_ready,
    input  logic              buffer_full,
    output logic              data_1_en,
    output logic [DATA_W-1:0] data_1,
    output logic              owner,
    output logic              busy,
    output logic [15:0]       words_sent
);

    localparam int CNT_W = $clog2(QUANTUM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  q_cnt;

    logic              out_rdy;
    logic              accept;
    logic              xfer;
    logic [DATA_W-1:0] xdata;
    logic              wr;
    logic [CNT_W-1:0]  q_cnt_nxt;
    logic              own_valid;
    logic              oth_valid;
    logic              rr_switch;

    // The stage can take a new word when empty or when its current word
    // leaves this same cycle.
    assign out_rdy   = !data_1_en || !buffer_full;

    // stop is looked at combinationally so nothing is accepted in the stop cycle.
    assign accept    = (state == RUN) && !stop && out_rdy;
    assign fib_ready = accept && !owner;
    assign tmr_ready = accept &&  owner;

    assign xfer      = (fib_valid && fib_ready) || (tmr_valid && tmr_ready);
    assign xdata     = owner ? tmr_data : fib_data;
    assign wr        = data_1_en && !buffer_full;

    assign own_valid = owner ? tmr_valid : fib_valid;
    assign oth_valid = owner ? fib_valid : tmr_valid;
    assign q_cnt_nxt = q_cnt + CNT_W'(xfer);

    // Hand over when the quantum is used up, or when the owner is idle but
    // the other producer has something to send.
    assign rr_switch = (q_cnt_nxt == CNT_W'(QUANTUM)) || (!own_valid && oth_valid);

    always_ff @(posedge clk_1) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 2'b00;
            q_cnt      <= '0;
            data_1_en  <= 1'b0;
            data_1     <= '0;
            owner      <= 1'b0;
            busy       <= 1'b0;
            words_sent <= 16'h0000;
        end else begin
            // Output stage: a transfer (re)loads it, otherwise a write empties it.
            if (xfer) begin
                data_1    <= xdata;
                data_1_en <= 1'b1;
            end else if (wr) begin
                data_1_en <= 1'b0;
            end

            if (wr)
                words_sent <= words_sent + 16'd1;

            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        mode_q     <= mode;
                        owner      <= (mode == 2'b01);
                        q_cnt      <= '0;
                        words_sent <= 16'h0000;
                    end
                end

                RUN: begin
                    if (mode_q[1]) begin
                        if (rr_switch) begin
                            owner <= !owner;
                            q_cnt <= '0;
                        end else begin
                            q_cnt <= q_cnt_nxt;
                        end
                    end else begin
                        owner <= mode_q[0];
                    end
                    if (stop)
                        state <= DRAIN;
                end

                DRAIN: begin
                    // Stay until the held word has been written.
                    if (!data_1_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
